// File: rtl/day12_ascii_tokenizer.sv
// day12_ascii_tokenizer: turns the Day-12 puzzle text (ASCII byte stream) into
// 32-bit tagged tokens (NUM / EOL / ROW / END) on a valid/ready output port.
// Optional build macro: DAY12_TOK_CHECKSUM_EN folds an XOR checksum of every
// emitted token into the low 16 bits of the END token.
module day12_ascii_tokenizer #(
  parameter int unsigned MAX_ROW_BITS = 8,
  parameter bit          CR_IGNORE    = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  input  logic        in_last,
  output logic        in_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic        err_sticky
);

  localparam int unsigned NUM_W  = 29;
  localparam int unsigned ROW_W  = 24;
  localparam int unsigned LEN_W  = 6;
  localparam int unsigned CNT_W  = 30;
  localparam int unsigned ACC_W  = 34;
`ifdef DAY12_TOK_CHECKSUM_EN
  // Only the low 14 bits of the token count are visible in END.
  localparam int unsigned TOK_CNT_W = 14;
`else
  localparam int unsigned TOK_CNT_W = 30;
`endif
  localparam logic [NUM_W-1:0] NUM_SAT = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACC_NUM,
    S_ACC_ROW,
    S_EMIT_EOL,
    S_FLUSH,
    S_EMIT_END
  } state_e;

  typedef enum logic [1:0] {
    P_NONE,
    P_NUM,
    P_ROW
  } pend_e;

  state_e                 state_q,    state_d;
  pend_e                  pend_q,     pend_d;
  logic [NUM_W-1:0]       acc_q,      acc_d;
  logic [ROW_W-1:0]       row_bits_q, row_bits_d;
  logic [LEN_W-1:0]       row_len_q,  row_len_d;
  logic [TOK_CNT_W-1:0]   tok_cnt_q,  tok_cnt_d;
  logic [CNT_W-1:0]       line_q,     line_d;
  logic                   err_q,      err_d;
  logic                   eol_pend_q, eol_pend_d;
  logic                   end_sent_q, end_sent_d;
  logic                   out_valid_q, out_valid_d;
  logic [31:0]            out_data_q, out_data_d;
`ifdef DAY12_TOK_CHECKSUM_EN
  logic [15:0]            chk_q,      chk_d;
`endif

  logic                   out_free;
  logic                   in_state_ok;
  logic                   accept;
  logic                   is_digit, is_hash, is_dot, is_row, is_sep, is_colon, is_nl, is_cr;
  logic [ACC_W-1:0]       acc_prod;
  logic [NUM_W-1:0]       acc_next;
  logic [CNT_W-1:0]       line_inc;
  logic [31:0]            row_tok, num_tok, pend_tok, flush_tok, eol_tok, end_tok;
  logic                   load_en;
  logic [31:0]            load_tok;

  // Handshake: bytes are taken only when the output register can absorb a token.
  assign out_free    = !out_valid_q || out_ready;
  assign in_state_ok = (state_q == S_IDLE) || (state_q == S_ACC_NUM) || (state_q == S_ACC_ROW);
  assign in_ready    = rst_n && out_free && in_state_ok;
  assign accept      = in_valid && in_ready;

  // Character classes.
  assign is_digit = (in_byte >= 8'h30) && (in_byte <= 8'h39);
  assign is_hash  = (in_byte == 8'h23);
  assign is_dot   = (in_byte == 8'h2E);
  assign is_row   = is_hash || is_dot;
  assign is_colon = (in_byte == 8'h3A);
  assign is_sep   = (in_byte == 8'h20) || (in_byte == 8'h78) || is_colon;
  assign is_nl    = (in_byte == 8'h0A);
  assign is_cr    = (in_byte == 8'h0D);

  // Saturating decimal accumulate; acc_q is zero whenever no number is pending.
  assign acc_prod = ACC_W'(acc_q) * ACC_W'(10) + ACC_W'(in_byte[3:0]);
  assign acc_next = (acc_prod > ACC_W'(NUM_SAT)) ? NUM_SAT : acc_prod[NUM_W-1:0];

  // Candidate token words.
  assign line_inc  = CNT_W'(line_q + 1'b1);
  assign row_tok   = {2'b10, row_len_q, row_bits_q};
  assign num_tok   = {2'b00, 1'b0, acc_q};
  assign pend_tok  = (pend_q == P_ROW) ? row_tok : {2'b00, is_colon, acc_q};
  assign flush_tok = (pend_q == P_ROW) ? row_tok : num_tok;
  assign eol_tok   = {2'b01, line_inc};
`ifdef DAY12_TOK_CHECKSUM_EN
  assign end_tok   = {2'b11, tok_cnt_q, chk_q};
`else
  assign end_tok   = {2'b11, tok_cnt_q};
`endif

  // Next-state, token assembly and output-register load.
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    acc_d       = acc_q;
    row_bits_d  = row_bits_q;
    row_len_d   = row_len_q;
    tok_cnt_d   = tok_cnt_q;
    line_d      = line_q;
    err_d       = err_q;
    eol_pend_d  = eol_pend_q;
    end_sent_d  = end_sent_q;
    out_valid_d = out_valid_q && !out_ready;
    out_data_d  = out_data_q;
`ifdef DAY12_TOK_CHECKSUM_EN
    chk_d       = chk_q;
`endif
    load_en     = 1'b0;
    load_tok    = '0;

    case (state_q)
      S_IDLE, S_ACC_NUM, S_ACC_ROW: begin
        if (accept) begin
          if (is_digit) begin
            if (pend_q == P_ROW) begin
              load_en  = 1'b1;
              load_tok = row_tok;
            end
            acc_d      = acc_next;
            row_bits_d = '0;
            row_len_d  = '0;
            pend_d     = P_NUM;
            state_d    = S_ACC_NUM;
          end else if (is_row) begin
            if (pend_q == P_NUM) begin
              load_en  = 1'b1;
              load_tok = num_tok;
            end
            if (row_len_q < LEN_W'(MAX_ROW_BITS)) begin
              row_bits_d = row_bits_q | (ROW_W'(is_hash) << row_len_q);
              row_len_d  = LEN_W'(row_len_q + 1'b1);
            end else begin
              err_d = 1'b1;
            end
            acc_d   = '0;
            pend_d  = P_ROW;
            state_d = S_ACC_ROW;
          end else if (is_cr && CR_IGNORE) begin
            state_d = state_q;
          end else begin
            // Separator, newline or illegal byte: close any pending token.
            if (pend_q != P_NONE) begin
              load_en  = 1'b1;
              load_tok = pend_tok;
            end
            acc_d      = '0;
            row_bits_d = '0;
            row_len_d  = '0;
            pend_d     = P_NONE;
            state_d    = S_IDLE;
            if (is_nl) begin
              if (pend_q != P_NONE) begin
                eol_pend_d = 1'b1;
                state_d    = S_EMIT_EOL;
              end else begin
                load_en  = 1'b1;
                load_tok = eol_tok;
                line_d   = line_inc;
              end
            end else if (!is_sep) begin
              err_d = 1'b1;
            end
          end
          if (in_last) begin
            state_d = S_FLUSH;
          end
        end
      end

      S_EMIT_EOL: begin
        if (out_free) begin
          load_en    = 1'b1;
          load_tok   = eol_tok;
          line_d     = line_inc;
          eol_pend_d = 1'b0;
          state_d    = S_IDLE;
        end
      end

      S_FLUSH: begin
        if (out_free) begin
          if (pend_q != P_NONE) begin
            load_en    = 1'b1;
            load_tok   = flush_tok;
            acc_d      = '0;
            row_bits_d = '0;
            row_len_d  = '0;
            pend_d     = P_NONE;
          end else if (eol_pend_q) begin
            load_en    = 1'b1;
            load_tok   = eol_tok;
            line_d     = line_inc;
            eol_pend_d = 1'b0;
          end else begin
            state_d = S_EMIT_END;
          end
        end
      end

      S_EMIT_END: begin
        if (!end_sent_q) begin
          if (out_free) begin
            out_valid_d = 1'b1;
            out_data_d  = end_tok;
            end_sent_d  = 1'b1;
          end
        end else if (out_ready) begin
          // END accepted downstream: start a fresh puzzle.
          tok_cnt_d  = '0;
          line_d     = '0;
          err_d      = 1'b0;
`ifdef DAY12_TOK_CHECKSUM_EN
          chk_d      = '0;
`endif
          end_sent_d = 1'b0;
          state_d    = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (load_en) begin
      out_valid_d = 1'b1;
      out_data_d  = load_tok;
      tok_cnt_d   = TOK_CNT_W'(tok_cnt_q + 1'b1);
`ifdef DAY12_TOK_CHECKSUM_EN
      chk_d       = chk_q ^ load_tok[31:16] ^ load_tok[15:0];
`endif
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pend_q      <= P_NONE;
      acc_q       <= '0;
      row_bits_q  <= '0;
      row_len_q   <= '0;
      tok_cnt_q   <= '0;
      line_q      <= '0;
      err_q       <= 1'b0;
      eol_pend_q  <= 1'b0;
      end_sent_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
`ifdef DAY12_TOK_CHECKSUM_EN
      chk_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      acc_q       <= acc_d;
      row_bits_q  <= row_bits_d;
      row_len_q   <= row_len_d;
      tok_cnt_q   <= tok_cnt_d;
      line_q      <= line_d;
      err_q       <= err_d;
      eol_pend_q  <= eol_pend_d;
      end_sent_q  <= end_sent_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
`ifdef DAY12_TOK_CHECKSUM_EN
      chk_q       <= chk_d;
`endif
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign err_sticky = err_q;

endmodule

// File: tb/tb_day12_ascii_tokenizer.sv
// Testbench for day12_ascii_tokenizer: table of text vectors with expected
// token streams, plus hand-written backpressure, reset and error sequences.
module tb_day12_ascii_tokenizer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_byte = 8'h00;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready = 1'b1;
  logic        err_sticky;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] got[$];
  logic [31:0] exp_q[$];

  typedef struct packed {
    logic [127:0] txt;
    logic [7:0]   len;
    logic         last;
    logic [3:0]   n;
    logic [191:0] exp;
    logic         err;
  } vec_t;

  vec_t vecs[9];

  day12_ascii_tokenizer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_byte    (in_byte),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .err_sticky (err_sticky)
  );

  always #5 clk = ~clk;

  // Capture every token handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) got.push_back(out_data);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] end_model();
`ifdef DAY12_TOK_CHECKSUM_EN
    logic [15:0] c;
    c = 16'h0000;
    foreach (exp_q[i]) c = c ^ exp_q[i][31:16] ^ exp_q[i][15:0];
    return {2'b11, 14'(exp_q.size()), c};
`else
    return {2'b11, 30'(exp_q.size())};
`endif
  endfunction

  task automatic do_reset();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_byte  = 8'h00;
    rst_n    = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    got.delete();
    exp_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    bit ok;
    ok       = 1'b0;
    in_byte  = b;
    in_last  = last;
    in_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: byte %h never accepted", b);
    end
  endtask

  task automatic send_str(input logic [127:0] txt, input int len, input bit last);
    for (int i = 0; i < len; i++) begin
      send_byte(txt[8*(len-1-i) +: 8], last && (i == len - 1));
    end
  endtask

  // Wait (bounded) for all expected tokens, then compare count and values.
  task automatic compare_all(input string name);
    for (int t = 0; t < 300 && got.size() < exp_q.size(); t++) @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
    check($sformatf("%s_count", name), 32'(got.size()), 32'(exp_q.size()));
    foreach (exp_q[i]) begin
      if (i < got.size()) check($sformatf("%s_tok%0d", name, i), got[i], exp_q[i]);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{txt: 128'("12x5: 1 0\n"), len: 8'd10, last: 1'b1, n: 4'd5,
                exp: 192'({32'h0000000C, 32'h20000005, 32'h00000001, 32'h00000000, 32'h40000001}),
                err: 1'b0};
    vecs[1] = '{txt: 128'("##.\n.#.\n"), len: 8'd8, last: 1'b0, n: 4'd4,
                exp: 192'({32'h83000003, 32'h40000001, 32'h83000002, 32'h40000002}), err: 1'b0};
    vecs[2] = '{txt: 128'("9999999999 "), len: 8'd11, last: 1'b0, n: 4'd1,
                exp: 192'(32'h1FFFFFFF), err: 1'b0};
    vecs[3] = '{txt: 128'("#########\n"), len: 8'd10, last: 1'b0, n: 4'd2,
                exp: 192'({32'h880000FF, 32'h40000001}), err: 1'b1};
    vecs[4] = '{txt: 128'("12"), len: 8'd2, last: 1'b1, n: 4'd1,
                exp: 192'(32'h0000000C), err: 1'b0};
    vecs[5] = '{txt: 128'("1#2\n"), len: 8'd4, last: 1'b0, n: 4'd4,
                exp: 192'({32'h00000001, 32'h81000001, 32'h00000002, 32'h40000001}), err: 1'b0};
    vecs[6] = '{txt: 128'("\n\n"), len: 8'd2, last: 1'b0, n: 4'd2,
                exp: 192'({32'h40000001, 32'h40000002}), err: 1'b0};
    vecs[7] = '{txt: 128'("5:x"), len: 8'd3, last: 1'b0, n: 4'd1,
                exp: 192'(32'h20000005), err: 1'b0};
    vecs[8] = '{txt: 128'("1\r\n"), len: 8'd3, last: 1'b0, n: 4'd2,
                exp: 192'({32'h00000001, 32'h40000001}), err: 1'b0};

    // Reset state, then in_ready on the first cycle after release.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_err", 32'(err_sticky), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Table-driven vectors, each from a fresh reset with out_ready held high.
    for (int v = 0; v < 9; v++) begin
      do_reset();
      out_ready = 1'b1;
      for (int k = 0; k < int'(vecs[v].n); k++) begin
        exp_q.push_back(vecs[v].exp[32*(int'(vecs[v].n)-1-k) +: 32]);
      end
      if (vecs[v].last) exp_q.push_back(end_model());
      send_str(vecs[v].txt, int'(vecs[v].len), vecs[v].last);
      compare_all($sformatf("vec%0d", v));
      check($sformatf("vec%0d_err", v), 32'(err_sticky), 32'(vecs[v].err));
    end

    // Backpressure: first token held stable, input stalled, EOL follows.
    do_reset();
    out_ready = 1'b0;
    send_byte(8'h37, 1'b0);
    send_byte(8'h0A, 1'b0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("bp_valid%0d", c), 32'(out_valid), 32'd1);
      check($sformatf("bp_data%0d", c), out_data, 32'h00000007);
      check($sformatf("bp_in_ready%0d", c), 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    exp_q.push_back(32'h00000007);
    exp_q.push_back(32'h40000001);
    compare_all("bp");

    // Reset in the middle of a number discards it.
    do_reset();
    out_ready = 1'b1;
    send_byte(8'h31, 1'b0);
    send_byte(8'h32, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("midrst_no_token", 32'(got.size()), 32'd0);
    exp_q.push_back(32'h00000005);
    exp_q.push_back(32'h40000001);
    exp_q.push_back(end_model());
    send_str(128'("5\n"), 2, 1'b1);
    compare_all("midrst");

    // Illegal char acts as separator and sets err_sticky until END.
    do_reset();
    out_ready = 1'b1;
    exp_q.push_back(32'h00000003);
    exp_q.push_back(32'h00000004);
    exp_q.push_back(32'h40000001);
    send_str(128'("3?4\n"), 4, 1'b0);
    compare_all("illegal");
    check("illegal_err_set", 32'(err_sticky), 32'd1);
    exp_q.push_back(end_model());
    send_byte(8'h20, 1'b1);
    compare_all("illegal_end");
    check("illegal_err_clear", 32'(err_sticky), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
